// File: rtl/multi_clock_gen_pkg.sv
// Shared definitions for the multi-channel clock generator: source select
// encodings and the divide-ratio clamp.
package clocking_pkg;

  typedef enum logic [1:0] {
    SEL_OFF     = 2'b00,
    SEL_PLL     = 2'b01,
    SEL_EXT     = 2'b10,
    SEL_OFF_ALT = 2'b11
  } clk_sel_e;

  // Ratios 0 and 1 cannot form a high and a low phase, so they run as 2.
  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction

endpackage

// File: rtl/multi_clock_gen_if.sv
// Configuration request channel of multi_clock_gen: the requester holds
// valid and payload until cfg_ready is seen high.
interface multi_clock_gen_if #(
  parameter int NCH  = 2,
  parameter int DIVW = 4
) ();

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic            cfg_valid;
  logic [CHW-1:0]  cfg_ch;
  logic [1:0]      cfg_sel;
  logic [DIVW-1:0] cfg_div;
  logic            cfg_ready;

  modport master (output cfg_valid, cfg_ch, cfg_sel, cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_sel, cfg_div, output cfg_ready);

endinterface

// File: rtl/multi_clock_gen_clock_div_chan.sv
// One output channel: active/pending configuration, phase counter and the
// output flop, switching configuration only at a glitch-free low boundary.
module clock_div_chan
  import clocking_pkg::*;
#(
  parameter int          DIVW      = 4,
  parameter logic [1:0]  RESET_SEL = 2'b01,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            ext_s,
  input  logic            load_valid,
  input  logic [1:0]      load_sel,
  input  logic [DIVW-1:0] load_div,
  output logic            clk_out,
  output logic            busy
);

  localparam logic [DIVW-1:0] ONE     = DIVW'(1);
  localparam logic [DIVW-1:0] RST_DIV = DIVW'(clamp_div(RESET_DIV));
  localparam logic [DIVW-1:0] RST_HI  = RST_DIV >> 1;

  clk_sel_e        act_sel_q, act_sel_d, pend_sel_q, pend_sel_d;
  logic [DIVW-1:0] act_div_q, act_div_d, pend_div_q, pend_div_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d, gap_q, gap_d, out_q, out_d;
  logic            boundary;

  function automatic logic [DIVW-1:0] hi_len(input logic [DIVW-1:0] d);
    return d >> 1;
  endfunction

  function automatic logic [DIVW-1:0] lo_len(input logic [DIVW-1:0] d);
    return d - (d >> 1);
  endfunction

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      act_sel_q  <= clk_sel_e'(RESET_SEL);
      act_div_q  <= RST_DIV;
      pend_sel_q <= SEL_OFF;
      pend_div_q <= RST_DIV;
      cnt_q      <= RST_HI;
      pend_q     <= 1'b0;
      gap_q      <= 1'b1;
      out_q      <= 1'b0;
    end else begin
      act_sel_q  <= act_sel_d;
      act_div_q  <= act_div_d;
      pend_sel_q <= pend_sel_d;
      pend_div_q <= pend_div_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      gap_q      <= gap_d;
      out_q      <= out_d;
    end
  end

  // gap_q marks the single low cycle after a reset or reload; the next edge
  // starts a fresh high phase with cnt already holding its length.
  always_comb begin
    act_sel_d  = act_sel_q;
    act_div_d  = act_div_q;
    pend_sel_d = pend_sel_q;
    pend_div_d = pend_div_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    gap_d      = gap_q;
    out_d      = out_q;
    boundary   = 1'b0;

    unique case (act_sel_q)
      SEL_PLL: boundary = ~out_q & (gap_q | (cnt_q == ONE));
      SEL_EXT: boundary = ~out_q & ~ext_s;
      default: boundary = ~out_q;
    endcase

    if (pend_q && boundary) begin
      act_sel_d = pend_sel_q;
      act_div_d = pend_div_q;
      cnt_d     = hi_len(pend_div_q);
      gap_d     = 1'b1;
      out_d     = 1'b0;
      pend_d    = 1'b0;
    end else begin
      unique case (act_sel_q)
        SEL_PLL: begin
          if (gap_q) begin
            out_d = 1'b1;
            gap_d = 1'b0;
          end else if (cnt_q == ONE) begin
            out_d = ~out_q;
            cnt_d = out_q ? lo_len(act_div_q) : hi_len(act_div_q);
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        SEL_EXT: out_d = ext_s;
        default: out_d = 1'b0;
      endcase
    end

    if (load_valid && !pend_q) begin
      pend_d     = 1'b1;
      pend_sel_d = clk_sel_e'(load_sel);
      pend_div_d = load_div;
    end
  end

  assign clk_out = out_q;
  assign busy    = pend_q;

endmodule

// File: rtl/multi_clock_gen.sv
// Multi-channel clock generator top: pad clock synchroniser, configuration
// decode onto the channels, and the ext_reset-aware core reset stager.
module multi_clock_gen
  import clocking_pkg::*;
#(
  parameter int          NCH        = 2,
  parameter int          DIVW       = 4,
  parameter int          RST_STAGES = 3,
  parameter logic [1:0]  RESET_SEL  = 2'b01,
  parameter int unsigned RESET_DIV  = 2
) (
  input  logic              pll_clk,
  input  logic              resetb,
  input  logic              ext_clk,
  input  logic              ext_reset,
  multi_clock_gen_if.slave  cfg,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    ch_busy,
  output logic              resetb_sync
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RCW = $clog2(RST_STAGES + 1);
  localparam logic [RCW-1:0] RST_DONE = RCW'(RST_STAGES);

  logic            ext_s1_q, ext_s1_d, ext_s2_q, ext_s2_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [NCH-1:0]  load_valid;
  logic [DIVW-1:0] load_div;
  logic            cfg_ready_c;

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      ext_s1_q  <= 1'b0;
      ext_s2_q  <= 1'b0;
      rst_cnt_q <= '0;
    end else begin
      ext_s1_q  <= ext_s1_d;
      ext_s2_q  <= ext_s2_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  always_comb begin
    ext_s1_d  = ext_clk;
    ext_s2_d  = ext_s1_q;
    rst_cnt_d = rst_cnt_q;
    if (ext_reset) begin
      rst_cnt_d = '0;
    end else if (rst_cnt_q != RST_DONE) begin
      rst_cnt_d = rst_cnt_q + RCW'(1);
    end
  end

  assign resetb_sync = (rst_cnt_q == RST_DONE);

  // A channel index beyond NCH is accepted and dropped so the requester never stalls.
  always_comb begin
    cfg_ready_c = 1'b1;
    load_valid  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg.cfg_ch == CHW'(i)) begin
        cfg_ready_c   = ~ch_busy[i];
        load_valid[i] = cfg.cfg_valid & ~ch_busy[i];
      end
    end
  end

  assign cfg.cfg_ready = cfg_ready_c;
  assign load_div      = DIVW'(clamp_div(32'(cfg.cfg_div)));

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clock_div_chan #(
      .DIVW      (DIVW),
      .RESET_SEL (RESET_SEL),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .clk        (pll_clk),
      .resetb     (resetb),
      .ext_s      (ext_s2_q),
      .load_valid (load_valid[g]),
      .load_sel   (cfg.cfg_sel),
      .load_div   (load_div),
      .clk_out    (clk_out[g]),
      .busy       (ch_busy[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Testbench for multi_clock_gen: directed scenarios plus random reconfiguration,
// compared every cycle against a period-position model of each channel.
module tb_multi_clock_gen;

  localparam int NCH        = 2;
  localparam int DIVW       = 4;
  localparam int CHW        = 1;
  localparam int RST_STAGES = 3;
  localparam int RESET_DIV  = 2;
  localparam int OFF = 0, PLL = 1, EXT = 2;

  logic           pll_clk = 1'b0;
  logic           resetb = 1'b0;
  logic           ext_clk = 1'b0;
  logic           ext_reset = 1'b0;
  logic [NCH-1:0] clk_out, ch_busy;
  logic           resetb_sync;

  multi_clock_gen_if #(.NCH(NCH), .DIVW(DIVW)) cfg_if ();

  multi_clock_gen #(
    .NCH(NCH), .DIVW(DIVW), .RST_STAGES(RST_STAGES),
    .RESET_SEL(2'b01), .RESET_DIV(RESET_DIV)
  ) dut (
    .pll_clk(pll_clk), .resetb(resetb), .ext_clk(ext_clk), .ext_reset(ext_reset),
    .cfg(cfg_if), .clk_out(clk_out), .ch_busy(ch_busy), .resetb_sync(resetb_sync)
  );

  always #5 pll_clk = ~pll_clk;

  // Reference model: each PLL channel sits at a position 0..N-1 in its period
  // (high while pos < N/2); pos N-1 is the last low slot where a switch may land.
  int m_sel [NCH], m_div [NCH], m_pos [NCH], m_psel [NCH], m_pdiv [NCH];
  bit m_out [NCH], m_pend [NCH];
  bit m_s1, m_s2, last_acc;
  int quiet;
  int ext_half = 4, ext_cnt = 0;
  int n_vec = 0, n_err = 0;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_sel[c] = PLL; m_div[c] = RESET_DIV; m_pos[c] = RESET_DIV - 1;
      m_out[c] = 1'b0; m_pend[c] = 1'b0; m_psel[c] = OFF; m_pdiv[c] = RESET_DIV;
    end
    m_s1 = 1'b0; m_s2 = 1'b0; quiet = 0; last_acc = 1'b0;
  endtask

  task automatic model_edge();
    int ch;
    bit acc, can_switch;
    ch  = int'(cfg_if.cfg_ch);
    acc = cfg_if.cfg_valid && !m_pend[ch];
    for (int c = 0; c < NCH; c++) begin
      if (m_sel[c] == PLL)      can_switch = !m_out[c] && (m_pos[c] == m_div[c] - 1);
      else if (m_sel[c] == EXT) can_switch = !m_out[c] && !m_s2;
      else                      can_switch = !m_out[c];
      if (m_pend[c] && can_switch) begin
        m_sel[c] = m_psel[c]; m_div[c] = m_pdiv[c];
        m_pos[c] = m_pdiv[c] - 1; m_out[c] = 1'b0; m_pend[c] = 1'b0;
      end else if (m_sel[c] == PLL) begin
        m_pos[c] = (m_pos[c] + 1) % m_div[c];
        m_out[c] = (m_pos[c] < m_div[c] / 2);
      end else if (m_sel[c] == EXT) begin
        m_out[c] = m_s2;
      end else begin
        m_out[c] = 1'b0;
      end
    end
    if (acc) begin
      m_pend[ch] = 1'b1;
      m_psel[ch] = int'(cfg_if.cfg_sel);
      m_pdiv[ch] = (cfg_if.cfg_div < 2) ? 2 : int'(cfg_if.cfg_div);
    end
    m_s2 = m_s1; m_s1 = ext_clk;
    quiet = ext_reset ? 0 : quiet + 1;
    last_acc = acc;
  endtask

  task automatic checkOutput();
    logic [NCH-1:0] e_out, e_busy;
    logic e_sync, e_ready;
    for (int c = 0; c < NCH; c++) begin
      e_out[c] = m_out[c]; e_busy[c] = m_pend[c];
    end
    e_sync  = (quiet >= RST_STAGES);
    e_ready = !m_pend[int'(cfg_if.cfg_ch)];
    n_vec++;
    assert (clk_out === e_out) else begin
      n_err++; $error("[TB] FAIL clk_out @%0t: got %b, expected %b", $time, clk_out, e_out);
    end
    n_vec++;
    assert (ch_busy === e_busy) else begin
      n_err++; $error("[TB] FAIL ch_busy @%0t: got %b, expected %b", $time, ch_busy, e_busy);
    end
    n_vec++;
    assert (resetb_sync === e_sync) else begin
      n_err++; $error("[TB] FAIL resetb_sync @%0t: got %b, expected %b", $time, resetb_sync, e_sync);
    end
    n_vec++;
    assert (cfg_if.cfg_ready === e_ready) else begin
      n_err++; $error("[TB] FAIL cfg_ready @%0t: got %b, expected %b", $time, cfg_if.cfg_ready, e_ready);
    end
  endtask

  // One pll_clk cycle: advance the pad clock, step the model on the rising
  // edge, compare on the falling edge.
  task automatic applyStimulus();
    ext_cnt++;
    if (ext_cnt >= ext_half) begin
      ext_cnt = 0; ext_clk = ~ext_clk;
    end
    @(posedge pll_clk);
    if (!resetb) model_reset();
    else         model_edge();
    @(negedge pll_clk);
    checkOutput();
  endtask

  task automatic send_cfg(input int ch, input int sel, input int div, output int waited);
    bit accepted;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CHW'(ch);
    cfg_if.cfg_sel   = 2'(sel);
    cfg_if.cfg_div   = DIVW'(div);
    accepted = 1'b0;
    waited   = 0;
    while (!accepted && waited < 40) begin
      applyStimulus();
      waited++;
      accepted = last_acc;
    end
    cfg_if.cfg_valid = 1'b0;
    n_vec++;
    assert (accepted) else begin
      n_err++; $error("[TB] FAIL accept_timeout ch%0d: got no acceptance in %0d cycles, expected one", ch, waited);
    end
  endtask

  initial begin
    int w, w1, guard, gap;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_sel   = 2'b01;
    cfg_if.cfg_div   = DIVW'(2);
    model_reset();

    $display("[TB] reset and post-reset divide-by-2");
    repeat (3) applyStimulus();
    resetb = 1'b1;
    repeat (8) applyStimulus();

    $display("[TB] ch0 to div 5");
    send_cfg(0, PLL, 5, w);
    repeat (20) applyStimulus();

    $display("[TB] ch1 to ext, then back to PLL div 3");
    send_cfg(1, EXT, 2, w);
    repeat (24) applyStimulus();
    send_cfg(1, PLL, 3, w);
    repeat (16) applyStimulus();

    $display("[TB] stalled request on busy ch0, ch1 unaffected");
    send_cfg(0, PLL, 9, w);
    send_cfg(1, PLL, 4, w1);
    n_vec++;
    assert (w1 === 1) else begin
      n_err++; $error("[TB] FAIL ch1_accept_wait: got %0d cycles, expected 1", w1);
    end
    send_cfg(0, PLL, 6, w);
    repeat (20) applyStimulus();

    $display("[TB] div 0 and 1 clamp to 2");
    send_cfg(0, PLL, 0, w);
    repeat (10) applyStimulus();
    send_cfg(1, PLL, 1, w);
    repeat (10) applyStimulus();

    $display("[TB] ext_reset pulse");
    ext_reset = 1'b1;
    repeat (2) applyStimulus();
    ext_reset = 1'b0;
    repeat (8) applyStimulus();

    $display("[TB] random reconfiguration");
    for (int k = 0; k < 150; k++) begin
      if (k % 40 == 39) ext_half = $urandom_range(3, 6);
      if ($urandom_range(0, 19) == 0) begin
        ext_reset = 1'b1;
        repeat (2) applyStimulus();
        ext_reset = 1'b0;
      end
      gap = $urandom_range(0, 5);
      repeat (gap) applyStimulus();
      send_cfg($urandom_range(0, NCH - 1), $urandom_range(0, 3), $urandom_range(0, 15), w);
    end
    repeat (20) applyStimulus();

    $display("[TB] resetb asserted while ch0 pending");
    send_cfg(0, PLL, 15, w);
    repeat (20) applyStimulus();
    guard = 0;
    while (clk_out[0] !== 1'b1 && guard < 40) begin
      applyStimulus();
      guard++;
    end
    n_vec++;
    assert (clk_out[0] === 1'b1) else begin
      n_err++; $error("[TB] FAIL ch0_high_wait: got %b, expected 1", clk_out[0]);
    end
    send_cfg(0, EXT, 3, w);
    applyStimulus();
    n_vec++;
    assert (ch_busy[0] === 1'b1) else begin
      n_err++; $error("[TB] FAIL ch0_pending: got %b, expected 1", ch_busy[0]);
    end
    resetb = 1'b0;
    #1;
    n_vec++;
    assert (clk_out === 2'b00) else begin
      n_err++; $error("[TB] FAIL async_clk_out: got %b, expected 00", clk_out);
    end
    n_vec++;
    assert (ch_busy === 2'b00) else begin
      n_err++; $error("[TB] FAIL async_ch_busy: got %b, expected 00", ch_busy);
    end
    model_reset();
    repeat (3) applyStimulus();
    resetb = 1'b1;
    repeat (12) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_clock_gen.md
# multi_clock_gen

Parametrised, multi-channel clock generator for the management/user clock tree. It produces NCH clock outputs from pll_clk, each with its own divider, source select and glitch-free reconfiguration. It synchronises the external pad clock into the pll_clk domain and generates a staged, ext_reset-aware core reset. It supersedes the fixed two-output clocking block, whose sources are switched only at reset.

## Interface
Parameters:
- NCH, 2: number of clock output channels (1..8).
- DIVW, 4: divider ratio width; ratio range 2..2^DIVW-1.
- RST_STAGES, 3: pll_clk cycles between reset-release conditions and resetb_sync rising.
- RESET_SEL, 2'b01: per-channel source after reset, same value for all channels.
- RESET_DIV, 2: per-channel divide ratio after reset.

Ports:
- pll_clk  in  1  all logic is clocked on the rising edge.
- resetb  in  1  asynchronous, active-low master reset.
- ext_clk  in  1  pad clock, asynchronous to pll_clk; frequency < pll_clk/4.
- ext_reset  in  1  positive reset request from housekeeping SPI; level-sensitive.
- cfg_valid  in  1  configuration request.
- cfg_ch  in  $clog2(NCH) (min 1)  target channel.
- cfg_sel  in  2  source select: 00 off, 01 PLL-divided, 10 ext (synced), 11 off.
- cfg_div  in  DIVW  divide ratio; values 0 and 1 clamp to 2.
- cfg_ready  out  1  equals ~pending[cfg_ch]; combinational from cfg_ch and pending.
- clk_out  out  NCH  registered channel clocks.
- ch_busy  out  NCH  pending bit per channel.
- resetb_sync  out  1  staged core reset, active-low.

## Operation
- ext_clk passes through two flops (ext_s1, ext_s2); ext_s2 is the ext source for every channel.
- Per-channel state: active sel/div, pending sel/div, pending flag, down-counter cnt[DIVW-1:0], output flop.
- PLL mode, ratio N:
  - high for N>>1 cycles, then low for N-(N>>1) cycles, repeating.
  - cnt reloads at each phase change.
- Ext mode: clk_out <= ext_s2 each cycle.
- Off mode: clk_out held 0.
- Handshake:
  - A request is accepted when cfg_valid && cfg_ready.
  - On acceptance, cfg_sel and clamped cfg_div are latched into the channel's pending registers and pending sets.
  - Requests to a busy channel are stalled (cfg_ready=0). The requester holds cfg_valid and the payload.
- Switch boundary: the first cycle in which the channel's current output is 0 and:
  - PLL mode: the low phase is on its last cycle (cnt==1).
  - Ext mode: ext_s2==0.
  - Off mode: immediately.
- At the boundary edge:
  - clk_out stays 0 (one guaranteed gap cycle).
  - active is loaded from pending, cnt is reloaded, pending clears.
  - New PLL config: the output goes high on the next edge.
  - New ext config: the output follows ext_s2 from the next edge.
  - No high pulse shorter than min(old,new) high phase is ever emitted.
- A request identical to the active config is still accepted and still takes one boundary (one extra low cycle).
- Reset staging:
  - rst_cnt counts pll_clk cycles while resetb=1 and ext_reset=0.
  - resetb_sync = (rst_cnt==RST_STAGES).
  - ext_reset assertion clears rst_cnt synchronously and drops resetb_sync on the next edge.
  - Channel clocks keep running during ext_reset.

## Timing
- Reset values:
  - clk_out=0, ch_busy=0, cfg_ready=1, resetb_sync=0.
  - active sel/div = RESET_SEL/RESET_DIV; cnt loaded for a high phase.
  - ext_s1/ext_s2 = 0.
- After resetb rises:
  - The first clk_out high is on edge 1 (PLL mode).
  - resetb_sync rises on edge RST_STAGES.
- Config latency: acceptance edge t; pending visible at t+1; the load edge is the first boundary at or after t+1.
- Worst-case load edge (PLL mode): t + old N + 1 cycles.
- ext_clk to clk_out latency: 3 pll_clk edges.
- resetb assertion mid-switch: pending is discarded and the channel returns to its reset config asynchronously.
- Simultaneous cfg acceptance and boundary on the same channel cannot occur, because cfg_ready is 0 while pending.

## Structure
- Package clocking_pkg holds:
  - sel encodings: SEL_OFF=2'b00, SEL_PLL=2'b01, SEL_EXT=2'b10.
  - function clamp_div(): values below 2 return 2.
- Sub-module clock_div_chan (one instance per channel, generate loop) contains:
  - pending/active registers, counter, boundary detect and output flop.
  - ports: clk, resetb, ext_s, load_valid, load_sel, load_div, clk_out, busy.
- Top level holds ext sync, cfg decode and reset stager.
- Expected size: ~250 lines.

## Test plan
- Reset with RESET_DIV=2, NCH=2:
  - clk_out toggles every cycle from edge 1, pattern 1,0,1,0.
  - resetb_sync=1 at edge 3.
- Ch0 switched to div=5 while at div=2:
  - Exactly one 0-gap cycle at the boundary.
  - Then pattern high 2 / low 3.
  - ch_busy[0] is high from t+1 until the load edge.
- Ch1 switched to ext mode, ext_clk = pll/8:
  - clk_out[1] follows ext_clk delayed 3 edges.
  - Switch back to PLL div=3: no high pulse <1 cycle, first high after ext low.
- Second request to busy ch0 while cfg_valid is held:
  - cfg_ready=0 until the load edge.
  - Accepted on the following cycle; ch1 requests are unaffected and accepted immediately.
- cfg_div=0 and 1: behave as div=2.
- ext_reset pulsed for 2 cycles:
  - resetb_sync low from the next edge.
  - High again RST_STAGES cycles after ext_reset falls.
  - clk_out keeps toggling throughout.
- resetb asserted while ch0 is pending: clk_out=0 and ch_busy=0 immediately; the RESET config resumes after release.
